// File: rtl/block_mover_pkg.sv
// block_mover_pkg
// Shared definitions for the block mover: default widths, the transfer
// state enumeration and the BLCK_SECTION field encodings.
package block_mover_pkg;

  localparam int ADDR_W_DEF = 12;
  localparam int DATA_W_DEF = 32;
  localparam int CNT_W_DEF  = 6;

  // Bit positions inside BLCK_SECTION.
  localparam int SEC_DIR_BIT = 0;
  localparam int SEC_DEV_BIT = 1;

  // Transfer direction carried by BLCK_SECTION[SEC_DIR_BIT].
  typedef enum logic {
    DIR_DEV2MEM = 1'b0,
    DIR_MEM2DEV = 1'b1
  } dir_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_MRD,
    ST_MWAIT,
    ST_DOUT,
    ST_DIN,
    ST_MWR,
    ST_DONE
  } state_t;

endpackage

// File: rtl/block_mover_issue_toggle_det.sv
// issue_toggle_det
// Turns the toggle-encoded BLCK_ISSUE strobe into a one-cycle command pulse.
// A registered copy of the strobe is refreshed every cycle; any difference
// between the live input and the copy is one command.
// Ports:
//   CLK       clock, rising edge
//   RST       asynchronous active-high reset (copy cleared to 0)
//   issue     toggle strobe
//   cmd_pulse high for the cycle in which issue differs from its copy
module issue_toggle_det (
  input  logic CLK,
  input  logic RST,
  input  logic issue,
  output logic cmd_pulse
);

  logic issue_q;

  // NOTE: clocked state is always assigned with <= so every flop samples
  // pre-edge values regardless of process evaluation order.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) issue_q <= 1'b0;
    else     issue_q <= issue;
  end

  // Copy resets to 0, so an issue line already high at reset release is
  // seen as one command in the first cycle.
  assign cmd_pulse = issue ^ issue_q;

endmodule

// File: rtl/block_mover.sv
// block_mover
// Moves a block of words between word-addressed memory and a streaming
// device. A command (toggle on BLCK_ISSUE) is accepted only in IDLE; the
// parameters are latched and the FSM walks one word at a time until the
// requested count is reached, the device reports an error, or BLCK_ABORT
// forces termination. DONE lasts one cycle and raises BLCK_IRQ.
// Ports:
//   CLK, RST                 clock / async active-high reset
//   BLCK_ISSUE               toggle command strobe
//   BLCK_START               first memory word address
//   BLCK_COUNT_REQ           words to move
//   BLCK_SECTION             [0] direction (1 mem->dev), [1] device select
//   BLCK_ABORT               level abort request
//   BLCK_WORKING             command in progress (including DONE cycle)
//   BLCK_COUNT_SENT          words completed in current/last command
//   BLCK_IRQ                 one-cycle completion pulse
//   BLCK_ABRUPT_STOP         last command ended by abort
//   BLCK_FRDRAM_DEVERR       last command ended by device error
//   MEM_*                    memory port, read data valid one cycle after MEM_RE
//   DEV_SEL, DEV_OUT_*       device select and outbound valid/ready stream
//   DEV_IN_*                 inbound valid/ready stream with error flag
module block_mover
  import block_mover_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int CNT_W  = CNT_W_DEF
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              BLCK_ISSUE,
  input  logic [ADDR_W-1:0] BLCK_START,
  input  logic [CNT_W-1:0]  BLCK_COUNT_REQ,
  input  logic [1:0]        BLCK_SECTION,
  input  logic              BLCK_ABORT,
  output logic              BLCK_WORKING,
  output logic [CNT_W-1:0]  BLCK_COUNT_SENT,
  output logic              BLCK_IRQ,
  output logic              BLCK_ABRUPT_STOP,
  output logic              BLCK_FRDRAM_DEVERR,
  output logic [ADDR_W-1:0] MEM_ADDR,
  output logic              MEM_RE,
  input  logic [DATA_W-1:0] MEM_RDATA,
  output logic              MEM_WE,
  output logic [DATA_W-1:0] MEM_WDATA,
  output logic              DEV_SEL,
  output logic [DATA_W-1:0] DEV_OUT_DATA,
  output logic              DEV_OUT_VALID,
  input  logic              DEV_OUT_READY,
  input  logic [DATA_W-1:0] DEV_IN_DATA,
  input  logic              DEV_IN_VALID,
  output logic              DEV_IN_READY,
  input  logic              DEV_IN_ERR
);

  state_t state, state_nxt;

  logic              cmd_pulse;
  logic [ADDR_W-1:0] start_q;
  logic [CNT_W-1:0]  count_req_q;
  logic [CNT_W-1:0]  count_sent_q;
  logic [CNT_W-1:0]  count_inc;
  logic              dev_sel_q;
  logic [DATA_W-1:0] data_q;
  logic              abrupt_q;
  logic              deverr_q;

  logic last_word;
  logic abort_hit;
  logic accept;
  logic do_inc;
  logic cap_rdata;
  logic cap_din;
  logic set_deverr;

  issue_toggle_det u_issue_det (
    .CLK       (CLK),
    .RST       (RST),
    .issue     (BLCK_ISSUE),
    .cmd_pulse (cmd_pulse)
  );

  assign count_inc = count_sent_q + CNT_W'(1);
  assign last_word = (count_inc == count_req_q);
  // Abort is only meaningful while a transfer is actually moving words.
  assign abort_hit = BLCK_ABORT && (state != ST_IDLE) && (state != ST_DONE);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path
    // through the case leaves one unassigned and no latch is inferred.
    state_nxt     = state;
    accept        = 1'b0;
    do_inc        = 1'b0;
    cap_rdata     = 1'b0;
    cap_din       = 1'b0;
    set_deverr    = 1'b0;
    MEM_RE        = 1'b0;
    MEM_WE        = 1'b0;
    DEV_OUT_VALID = 1'b0;
    DEV_IN_READY  = 1'b0;

    if (abort_hit) begin
      // Strobes stay at their defaults: the write or handshake that would
      // have happened this cycle is suppressed, and abort outranks a
      // simultaneous device error.
      state_nxt = ST_DONE;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (cmd_pulse) begin
            accept = 1'b1;
            if (BLCK_COUNT_REQ == '0)
              state_nxt = ST_DONE;
            else if (dir_t'(BLCK_SECTION[SEC_DIR_BIT]) == DIR_MEM2DEV)
              state_nxt = ST_MRD;
            else
              state_nxt = ST_DIN;
          end
        end
        ST_MRD: begin
          MEM_RE    = 1'b1;
          state_nxt = ST_MWAIT;
        end
        ST_MWAIT: begin
          cap_rdata = 1'b1;
          state_nxt = ST_DOUT;
        end
        ST_DOUT: begin
          DEV_OUT_VALID = 1'b1;
          if (DEV_OUT_READY) begin
            do_inc    = 1'b1;
            state_nxt = last_word ? ST_DONE : ST_MRD;
          end
        end
        ST_DIN: begin
          DEV_IN_READY = 1'b1;
          if (DEV_IN_VALID) begin
            if (DEV_IN_ERR) begin
              set_deverr = 1'b1;
              state_nxt  = ST_DONE;
            end else begin
              cap_din   = 1'b1;
              state_nxt = ST_MWR;
            end
          end
        end
        ST_MWR: begin
          MEM_WE    = 1'b1;
          do_inc    = 1'b1;
          state_nxt = last_word ? ST_DONE : ST_DIN;
        end
        ST_DONE: state_nxt = ST_IDLE;
        default: state_nxt = ST_IDLE;
      endcase
    end
  end

  // NOTE: the datapath registers are plain flops (no RAM), so they are all
  // reset; that also forces MEM_ADDR and DEV_SEL to 0 during reset.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      start_q      <= '0;
      count_req_q  <= '0;
      count_sent_q <= '0;
      dev_sel_q    <= 1'b0;
      data_q       <= '0;
      abrupt_q     <= 1'b0;
      deverr_q     <= 1'b0;
    end else begin
      if (accept) begin
        start_q      <= BLCK_START;
        count_req_q  <= BLCK_COUNT_REQ;
        dev_sel_q    <= BLCK_SECTION[SEC_DEV_BIT];
        count_sent_q <= '0;
        abrupt_q     <= 1'b0;
        deverr_q     <= 1'b0;
      end
      if (abort_hit)  abrupt_q     <= 1'b1;
      if (do_inc)     count_sent_q <= count_inc;
      if (cap_rdata)  data_q       <= MEM_RDATA;
      if (cap_din)    data_q       <= DEV_IN_DATA;
      if (set_deverr) deverr_q     <= 1'b1;
    end
  end

  // Address wraps naturally at 2^ADDR_W.
  assign MEM_ADDR           = start_q + ADDR_W'(count_sent_q);
  assign MEM_WDATA          = data_q;
  assign DEV_OUT_DATA       = data_q;
  assign DEV_SEL            = dev_sel_q;
  assign BLCK_WORKING       = (state != ST_IDLE);
  assign BLCK_IRQ           = (state == ST_DONE);
  assign BLCK_COUNT_SENT    = count_sent_q;
  assign BLCK_ABRUPT_STOP   = abrupt_q;
  assign BLCK_FRDRAM_DEVERR = deverr_q;

endmodule

// File: tb/tb_block_mover.sv
// tb_block_mover
// Directed bench for block_mover: a memory model that returns a
// known function of the address, a device sink/source, and monitors
// that log every memory read/write, device handshake and IRQ cycle.
module tb_block_mover;
  import block_mover_pkg::*;

  localparam int ADDR_W = ADDR_W_DEF;
  localparam int DATA_W = DATA_W_DEF;
  localparam int CNT_W  = CNT_W_DEF;

  logic              CLK = 1'b0;
  logic              RST;
  logic              BLCK_ISSUE;
  logic [ADDR_W-1:0] BLCK_START;
  logic [CNT_W-1:0]  BLCK_COUNT_REQ;
  logic [1:0]        BLCK_SECTION;
  logic              BLCK_ABORT;
  logic              BLCK_WORKING;
  logic [CNT_W-1:0]  BLCK_COUNT_SENT;
  logic              BLCK_IRQ;
  logic              BLCK_ABRUPT_STOP;
  logic              BLCK_FRDRAM_DEVERR;
  logic [ADDR_W-1:0] MEM_ADDR;
  logic              MEM_RE;
  logic [DATA_W-1:0] MEM_RDATA;
  logic              MEM_WE;
  logic [DATA_W-1:0] MEM_WDATA;
  logic              DEV_SEL;
  logic [DATA_W-1:0] DEV_OUT_DATA;
  logic              DEV_OUT_VALID;
  logic              DEV_OUT_READY;
  logic [DATA_W-1:0] DEV_IN_DATA;
  logic              DEV_IN_VALID;
  logic              DEV_IN_READY;
  logic              DEV_IN_ERR;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 CLK = ~CLK;

  block_mover #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
    .CLK                (CLK),
    .RST                (RST),
    .BLCK_ISSUE         (BLCK_ISSUE),
    .BLCK_START         (BLCK_START),
    .BLCK_COUNT_REQ     (BLCK_COUNT_REQ),
    .BLCK_SECTION       (BLCK_SECTION),
    .BLCK_ABORT         (BLCK_ABORT),
    .BLCK_WORKING       (BLCK_WORKING),
    .BLCK_COUNT_SENT    (BLCK_COUNT_SENT),
    .BLCK_IRQ           (BLCK_IRQ),
    .BLCK_ABRUPT_STOP   (BLCK_ABRUPT_STOP),
    .BLCK_FRDRAM_DEVERR (BLCK_FRDRAM_DEVERR),
    .MEM_ADDR           (MEM_ADDR),
    .MEM_RE             (MEM_RE),
    .MEM_RDATA          (MEM_RDATA),
    .MEM_WE             (MEM_WE),
    .MEM_WDATA          (MEM_WDATA),
    .DEV_SEL            (DEV_SEL),
    .DEV_OUT_DATA       (DEV_OUT_DATA),
    .DEV_OUT_VALID      (DEV_OUT_VALID),
    .DEV_OUT_READY      (DEV_OUT_READY),
    .DEV_IN_DATA        (DEV_IN_DATA),
    .DEV_IN_VALID       (DEV_IN_VALID),
    .DEV_IN_READY       (DEV_IN_READY),
    .DEV_IN_ERR         (DEV_IN_ERR)
  );

  // Memory content is a fixed function of the address.
  function automatic logic [31:0] mem_val(input logic [11:0] a);
    return {a, 8'h5A, ~a};
  endfunction

  // ---- monitors / models ----
  int cyc = 0, rd_n = 0, wr_n = 0, out_n = 0, irq_n = 0, work_n = 0;
  int irq_cyc = 0, hs_cyc = 0;
  logic [11:0] rd_addr_log [256];
  logic [11:0] wr_addr_log [256];
  logic [31:0] wr_data_log [256];
  logic [31:0] out_log     [256];

  int          din_idx = 0;
  int          din_off = 0;
  int          din_n   = 0;
  int          err_k   = -1;
  logic        din_en  = 1'b0;
  logic [31:0] din_words [16];
  logic [3:0]  din_sel;

  assign din_sel      = 4'(din_idx - din_off);
  assign DEV_IN_DATA  = din_words[din_sel];
  assign DEV_IN_VALID = din_en && ((din_idx - din_off) < din_n);
  assign DEV_IN_ERR   = din_en && ((din_idx - din_off) == err_k);

  always @(posedge CLK) begin
    if (MEM_RE) begin
      MEM_RDATA <= mem_val(MEM_ADDR);
      rd_addr_log[8'(rd_n)] = MEM_ADDR;
      rd_n++;
    end
    if (MEM_WE) begin
      wr_addr_log[8'(wr_n)] = MEM_ADDR;
      wr_data_log[8'(wr_n)] = MEM_WDATA;
      wr_n++;
    end
    if (DEV_OUT_VALID && DEV_OUT_READY) begin
      out_log[8'(out_n)] = DEV_OUT_DATA;
      out_n++;
      hs_cyc = cyc;
    end
    if (DEV_IN_VALID && DEV_IN_READY) din_idx <= din_idx + 1;
    if (BLCK_IRQ) begin
      irq_n++;
      irq_cyc = cyc;
    end
    if (BLCK_WORKING) work_n++;
    cyc++;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached, expected $finish earlier");
    $fatal(1);
  end

  // ---- helpers (stimulus only) ----
  task automatic issue_cmd(input logic [11:0] start, input logic [5:0] cnt, input logic [1:0] sec);
    BLCK_START     = start;
    BLCK_COUNT_REQ = cnt;
    BLCK_SECTION   = sec;
    BLCK_ISSUE     = ~BLCK_ISSUE;
    @(negedge CLK);
  endtask

  task automatic wait_irq(input string name, input int budget);
    int n = 0;
    while (BLCK_IRQ !== 1'b1 && n < budget) begin
      @(negedge CLK);
      n++;
    end
    n_checks++;
    if (BLCK_IRQ !== 1'b1) begin
      n_fail++;
      $display("FAIL %s_irq_timeout: irq=%b after %0d cycles, expected 1", name, BLCK_IRQ, n);
    end
  endtask

  // ---- tests ----
  task automatic test_reset();
    RST = 1'b1;
    repeat (2) @(negedge CLK);
    n_checks++; if (BLCK_WORKING !== 1'b0) begin n_fail++; $display("FAIL reset_working: got %b exp 0", BLCK_WORKING); end
    n_checks++; if (BLCK_IRQ !== 1'b0) begin n_fail++; $display("FAIL reset_irq: got %b exp 0", BLCK_IRQ); end
    n_checks++; if ({MEM_RE, MEM_WE, DEV_OUT_VALID, DEV_IN_READY} !== 4'b0) begin n_fail++; $display("FAIL reset_strobes: got %b exp 0000", {MEM_RE, MEM_WE, DEV_OUT_VALID, DEV_IN_READY}); end
    n_checks++; if (BLCK_COUNT_SENT !== 6'd0) begin n_fail++; $display("FAIL reset_count_sent: got %0d exp 0", BLCK_COUNT_SENT); end
    n_checks++; if (MEM_ADDR !== 12'h000) begin n_fail++; $display("FAIL reset_mem_addr: got %h exp 000", MEM_ADDR); end
    n_checks++; if ({DEV_SEL, BLCK_ABRUPT_STOP, BLCK_FRDRAM_DEVERR} !== 3'b0) begin n_fail++; $display("FAIL reset_status: got %b exp 000", {DEV_SEL, BLCK_ABRUPT_STOP, BLCK_FRDRAM_DEVERR}); end
    RST = 1'b0;
    repeat (2) @(negedge CLK);
    n_checks++; if (BLCK_WORKING !== 1'b0) begin n_fail++; $display("FAIL reset_idle_after_release: working=%b exp 0", BLCK_WORKING); end
  endtask

  task automatic test_mem_to_dev();
    int r0 = rd_n, o0 = out_n, i0 = irq_n, w0 = wr_n;
    DEV_OUT_READY = 1'b1;
    issue_cmd(12'h010, 6'd4, 2'b01);
    n_checks++; if (BLCK_WORKING !== 1'b1) begin n_fail++; $display("FAIL m2d_working: got %b exp 1", BLCK_WORKING); end
    wait_irq("m2d", 100);
    n_checks++; if (BLCK_COUNT_SENT !== 6'd4) begin n_fail++; $display("FAIL m2d_count_sent: got %0d exp 4", BLCK_COUNT_SENT); end
    n_checks++; if (rd_n - r0 !== 4) begin n_fail++; $display("FAIL m2d_reads: got %0d exp 4", rd_n - r0); end
    n_checks++; if (out_n - o0 !== 4) begin n_fail++; $display("FAIL m2d_dev_words: got %0d exp 4", out_n - o0); end
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if (rd_addr_log[8'(r0 + i)] !== 12'h010 + 12'(i)) begin
        n_fail++; $display("FAIL m2d_rd_addr%0d: got %h exp %h", i, rd_addr_log[8'(r0 + i)], 12'h010 + 12'(i));
      end
      n_checks++;
      if (out_log[8'(o0 + i)] !== mem_val(12'h010 + 12'(i))) begin
        n_fail++; $display("FAIL m2d_dev_data%0d: got %h exp %h", i, out_log[8'(o0 + i)], mem_val(12'h010 + 12'(i)));
      end
    end
    n_checks++; if (DEV_SEL !== 1'b0) begin n_fail++; $display("FAIL m2d_dev_sel: got %b exp 0", DEV_SEL); end
    @(negedge CLK);
    n_checks++; if (irq_cyc - hs_cyc !== 1) begin n_fail++; $display("FAIL m2d_irq_latency: got %0d exp 1", irq_cyc - hs_cyc); end
    n_checks++; if (irq_n - i0 !== 1) begin n_fail++; $display("FAIL m2d_irq_pulses: got %0d exp 1", irq_n - i0); end
    n_checks++; if (BLCK_WORKING !== 1'b0) begin n_fail++; $display("FAIL m2d_idle: working=%b exp 0", BLCK_WORKING); end
    n_checks++; if (wr_n !== w0) begin n_fail++; $display("FAIL m2d_no_writes: got %0d exp %0d", wr_n, w0); end
  endtask

  task automatic test_dev_to_mem_wrap();
    int w0 = wr_n, i0 = irq_n, r0 = rd_n;
    logic [11:0] exp_a [3];
    exp_a[0] = 12'hFFE; exp_a[1] = 12'hFFF; exp_a[2] = 12'h000;
    din_words[0] = 32'hAAAA_0001; din_words[1] = 32'hBBBB_0002; din_words[2] = 32'hCCCC_0003;
    din_off = din_idx; din_n = 3; err_k = -1; din_en = 1'b1;
    issue_cmd(12'hFFE, 6'd3, 2'b00);
    wait_irq("d2m", 100);
    n_checks++; if (BLCK_COUNT_SENT !== 6'd3) begin n_fail++; $display("FAIL d2m_count_sent: got %0d exp 3", BLCK_COUNT_SENT); end
    n_checks++; if (wr_n - w0 !== 3) begin n_fail++; $display("FAIL d2m_writes: got %0d exp 3", wr_n - w0); end
    for (int i = 0; i < 3; i++) begin
      n_checks++;
      if (wr_addr_log[8'(w0 + i)] !== exp_a[i] || wr_data_log[8'(w0 + i)] !== din_words[i]) begin
        n_fail++; $display("FAIL d2m_write%0d: got %h=%h exp %h=%h", i, wr_addr_log[8'(w0 + i)], wr_data_log[8'(w0 + i)], exp_a[i], din_words[i]);
      end
    end
    n_checks++; if ({BLCK_ABRUPT_STOP, BLCK_FRDRAM_DEVERR} !== 2'b00) begin n_fail++; $display("FAIL d2m_status: got %b exp 00", {BLCK_ABRUPT_STOP, BLCK_FRDRAM_DEVERR}); end
    @(negedge CLK);
    din_en = 1'b0;
    n_checks++; if (irq_n - i0 !== 1) begin n_fail++; $display("FAIL d2m_irq_pulses: got %0d exp 1", irq_n - i0); end
    n_checks++; if (rd_n !== r0) begin n_fail++; $display("FAIL d2m_no_reads: got %0d exp %0d", rd_n, r0); end
  endtask

  task automatic test_zero_count();
    int wk0 = work_n, i0 = irq_n, r0 = rd_n, w0 = wr_n;
    issue_cmd(12'h123, 6'd0, 2'b01);
    n_checks++; if ({BLCK_WORKING, BLCK_IRQ} !== 2'b11) begin n_fail++; $display("FAIL zero_done_cycle: working,irq=%b exp 11", {BLCK_WORKING, BLCK_IRQ}); end
    @(negedge CLK);
    n_checks++; if (BLCK_WORKING !== 1'b0) begin n_fail++; $display("FAIL zero_idle: working=%b exp 0", BLCK_WORKING); end
    n_checks++; if (work_n - wk0 !== 1) begin n_fail++; $display("FAIL zero_working_cycles: got %0d exp 1", work_n - wk0); end
    n_checks++; if (irq_n - i0 !== 1) begin n_fail++; $display("FAIL zero_irq_pulses: got %0d exp 1", irq_n - i0); end
    n_checks++; if (rd_n !== r0 || wr_n !== w0) begin n_fail++; $display("FAIL zero_no_mem: reads %0d writes %0d exp 0 0", rd_n - r0, wr_n - w0); end
    n_checks++; if (BLCK_COUNT_SENT !== 6'd0) begin n_fail++; $display("FAIL zero_count_sent: got %0d exp 0", BLCK_COUNT_SENT); end
  endtask

  task automatic test_dev_err();
    int w0 = wr_n, i0 = irq_n;
    for (int i = 0; i < 8; i++) din_words[i] = 32'hD000_0000 + 32'(i);
    din_off = din_idx; din_n = 8; err_k = 2; din_en = 1'b1;
    issue_cmd(12'h100, 6'd8, 2'b10);
    wait_irq("err", 100);
    n_checks++; if (BLCK_COUNT_SENT !== 6'd2) begin n_fail++; $display("FAIL err_count_sent: got %0d exp 2", BLCK_COUNT_SENT); end
    n_checks++; if ({BLCK_FRDRAM_DEVERR, BLCK_ABRUPT_STOP} !== 2'b10) begin n_fail++; $display("FAIL err_status: deverr,abrupt=%b exp 10", {BLCK_FRDRAM_DEVERR, BLCK_ABRUPT_STOP}); end
    n_checks++; if (wr_n - w0 !== 2) begin n_fail++; $display("FAIL err_writes: got %0d exp 2", wr_n - w0); end
    n_checks++; if (wr_addr_log[8'(w0 + 1)] !== 12'h101 || wr_data_log[8'(w0 + 1)] !== 32'hD000_0001) begin n_fail++; $display("FAIL err_write1: got %h=%h exp 101=d0000001", wr_addr_log[8'(w0 + 1)], wr_data_log[8'(w0 + 1)]); end
    n_checks++; if (DEV_SEL !== 1'b1) begin n_fail++; $display("FAIL err_dev_sel: got %b exp 1", DEV_SEL); end
    @(negedge CLK);
    din_en = 1'b0; err_k = -1;
    n_checks++; if (irq_n - i0 !== 1) begin n_fail++; $display("FAIL err_irq_pulses: got %0d exp 1", irq_n - i0); end
  endtask

  task automatic test_abort();
    int o0 = out_n, i0 = irq_n, w0 = wr_n, n = 0;
    DEV_OUT_READY = 1'b1;
    issue_cmd(12'h200, 6'd8, 2'b01);
    while (out_n - o0 < 5 && n < 100) begin
      @(negedge CLK);
      n++;
    end
    n_checks++; if (out_n - o0 !== 5) begin n_fail++; $display("FAIL abort_fifth_handshake: got %0d words exp 5", out_n - o0); end
    // Second command toggled while the first is still running.
    BLCK_COUNT_REQ = 6'd2; BLCK_SECTION = 2'b00; BLCK_ISSUE = ~BLCK_ISSUE;
    @(negedge CLK);
    BLCK_ABORT = 1'b1;
    @(negedge CLK);
    BLCK_ABORT = 1'b0;
    n_checks++; if (BLCK_IRQ !== 1'b1) begin n_fail++; $display("FAIL abort_irq: got %b exp 1", BLCK_IRQ); end
    n_checks++; if (BLCK_ABRUPT_STOP !== 1'b1) begin n_fail++; $display("FAIL abort_abrupt: got %b exp 1", BLCK_ABRUPT_STOP); end
    n_checks++; if (BLCK_COUNT_SENT !== 6'd5) begin n_fail++; $display("FAIL abort_count_sent: got %0d exp 5", BLCK_COUNT_SENT); end
    repeat (10) @(negedge CLK);
    n_checks++; if (BLCK_WORKING !== 1'b0) begin n_fail++; $display("FAIL abort_second_toggle_ignored: working=%b exp 0", BLCK_WORKING); end
    n_checks++; if (irq_n - i0 !== 1 || out_n - o0 !== 5 || wr_n !== w0) begin n_fail++; $display("FAIL abort_activity: irq %0d words %0d writes %0d exp 1 5 0", irq_n - i0, out_n - o0, wr_n - w0); end
    n_checks++; if (out_log[8'(o0 + 4)] !== mem_val(12'h204)) begin n_fail++; $display("FAIL abort_word5: got %h exp %h", out_log[8'(o0 + 4)], mem_val(12'h204)); end
    n_checks++; if (BLCK_ABRUPT_STOP !== 1'b1) begin n_fail++; $display("FAIL abort_status_hold: got %b exp 1", BLCK_ABRUPT_STOP); end
  endtask

  task automatic test_reset_mid();
    int w0 = wr_n, w1, i0, n = 0;
    for (int i = 0; i < 8; i++) din_words[i] = 32'hE000_0000 + 32'(i);
    din_off = din_idx; din_n = 8; err_k = -1; din_en = 1'b1;
    issue_cmd(12'h300, 6'd8, 2'b10);
    // Stop on the cycle that is driving the second memory write.
    while (!(MEM_WE === 1'b1 && wr_n - w0 >= 1) && n < 100) begin
      @(negedge CLK);
      n++;
    end
    n_checks++; if (MEM_WE !== 1'b1) begin n_fail++; $display("FAIL rstmid_reach_write: mem_we=%b exp 1", MEM_WE); end
    w1 = wr_n; i0 = irq_n;
    RST = 1'b1;
    #1;
    n_checks++; if ({BLCK_WORKING, BLCK_IRQ, MEM_RE, MEM_WE, DEV_OUT_VALID, DEV_IN_READY} !== 6'b0) begin n_fail++; $display("FAIL rstmid_strobes: got %b exp 000000", {BLCK_WORKING, BLCK_IRQ, MEM_RE, MEM_WE, DEV_OUT_VALID, DEV_IN_READY}); end
    n_checks++; if (BLCK_COUNT_SENT !== 6'd0 || MEM_ADDR !== 12'h000) begin n_fail++; $display("FAIL rstmid_regs: count %0d addr %h exp 0 000", BLCK_COUNT_SENT, MEM_ADDR); end
    n_checks++; if ({DEV_SEL, BLCK_ABRUPT_STOP, BLCK_FRDRAM_DEVERR} !== 3'b0) begin n_fail++; $display("FAIL rstmid_status: got %b exp 000", {DEV_SEL, BLCK_ABRUPT_STOP, BLCK_FRDRAM_DEVERR}); end
    din_en = 1'b0;
    repeat (3) @(negedge CLK);
    n_checks++; if (wr_n !== w1 || irq_n !== i0) begin n_fail++; $display("FAIL rstmid_silent: writes %0d irqs %0d exp 0 0", wr_n - w1, irq_n - i0); end
  endtask

  task automatic test_issue_at_reset();
    int r0 = rd_n, w0 = wr_n;
    // Still in reset from the previous test.
    BLCK_ISSUE = 1'b1; BLCK_COUNT_REQ = 6'd0; BLCK_SECTION = 2'b01; BLCK_START = 12'h040;
    @(negedge CLK);
    RST = 1'b0;
    @(negedge CLK);
    n_checks++; if ({BLCK_WORKING, BLCK_IRQ} !== 2'b11) begin n_fail++; $display("FAIL issue_at_release: working,irq=%b exp 11", {BLCK_WORKING, BLCK_IRQ}); end
    repeat (3) @(negedge CLK);
    n_checks++; if (BLCK_WORKING !== 1'b0 || rd_n !== r0 || wr_n !== w0) begin n_fail++; $display("FAIL issue_at_release_single: working %b reads %0d writes %0d exp 0 0 0", BLCK_WORKING, rd_n - r0, wr_n - w0); end
  endtask

  initial begin
    RST = 1'b1; BLCK_ISSUE = 1'b0; BLCK_START = '0; BLCK_COUNT_REQ = '0;
    BLCK_SECTION = 2'b00; BLCK_ABORT = 1'b0; DEV_OUT_READY = 1'b0;
    for (int i = 0; i < 16; i++) din_words[i] = '0;
    test_reset();
    test_mem_to_dev();
    test_dev_to_mem_wrap();
    test_zero_count();
    test_dev_err();
    test_abort();
    test_reset_mid();
    test_issue_at_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/block_mover.md
BLOCK_MOVER -- requirements
Module: block_mover

Interface
REQ-001 Parameter ADDR_W, 12, memory word-address width (matches BLCK_START).
REQ-002 Parameter DATA_W, 32, word width on both memory and device ports.
REQ-003 Parameter CNT_W, 6, width of BLCK_COUNT_REQ and BLCK_COUNT_SENT.
REQ-004 CLK  in  1  sole clock; all logic on rising edge.
REQ-005 RST  in  1  reset, asynchronous, active-high.
REQ-006 BLCK_ISSUE  in  1  toggle-encoded command strobe; every level change is one command.
REQ-007 BLCK_START  in  ADDR_W  first memory word address; sampled at command accept.
REQ-008 BLCK_COUNT_REQ  in  CNT_W  words to move; sampled at accept.
REQ-009 BLCK_SECTION  in  2  bit0 = direction (1 mem->dev, 0 dev->mem), bit1 = device select; sampled at accept.
REQ-010 BLCK_ABORT  in  1  level; forces termination of a running transfer.
REQ-011 BLCK_WORKING  out  1  high while a command is in progress.
REQ-012 BLCK_COUNT_SENT  out  CNT_W  words completed in the current/last command.
REQ-013 BLCK_IRQ  out  1  one-cycle completion pulse.
REQ-014 BLCK_ABRUPT_STOP  out  1  last command ended by BLCK_ABORT.
REQ-015 BLCK_FRDRAM_DEVERR  out  1  last command ended by device error.
REQ-016 MEM_ADDR out ADDR_W; MEM_RE out 1; MEM_RDATA in DATA_W (valid one cycle after MEM_RE); MEM_WE out 1; MEM_WDATA out DATA_W.
REQ-017 DEV_SEL out 1 (latched BLCK_SECTION[1]); DEV_OUT_DATA out DATA_W, DEV_OUT_VALID out 1, DEV_OUT_READY in 1; DEV_IN_DATA in DATA_W, DEV_IN_VALID in 1, DEV_IN_READY out 1, DEV_IN_ERR in 1 (qualified by DEV_IN_VALID).

Function
REQ-018 A registered copy of BLCK_ISSUE shall be kept; command detected when input differs from copy; copy updates every cycle.
REQ-019 Detected command in IDLE shall be accepted: BLCK_WORKING high next cycle, COUNT_SENT cleared, ABRUPT_STOP and DEVERR cleared, parameters latched.
REQ-020 Command detected while not IDLE shall be discarded (no queueing, no state change).
REQ-021 States: IDLE, MRD, MWAIT, DOUT, DIN, MWR, DONE.
REQ-022 mem->dev: MRD drives MEM_RE=1, MEM_ADDR=start+COUNT_SENT -> MWAIT captures MEM_RDATA -> DOUT holds DEV_OUT_VALID until DEV_OUT_READY; on handshake COUNT_SENT+1, then MRD or DONE.
REQ-023 dev->mem: DIN drives DEV_IN_READY=1; on DEV_IN_VALID&&!DEV_IN_ERR capture data -> MWR drives MEM_WE=1 one cycle at start+COUNT_SENT, COUNT_SENT+1, then DIN or DONE.
REQ-024 Transfer reaches DONE when COUNT_SENT equals latched count after an increment.
REQ-025 BLCK_COUNT_REQ=0: accept goes directly to DONE; BLCK_WORKING high exactly one cycle, no memory or device cycles.
REQ-026 Address arithmetic shall be modulo 2^ADDR_W (0xFFF+1 wraps to 0x000).
REQ-027 DEV_IN_VALID&&DEV_IN_ERR in DIN: word discarded, BLCK_FRDRAM_DEVERR=1, go DONE.
REQ-028 BLCK_ABORT high in any state except IDLE/DONE: go DONE, BLCK_ABRUPT_STOP=1, in-flight MEM_WE/handshake of that cycle suppressed; abort wins over simultaneous device error.
REQ-029 DONE lasts one cycle: BLCK_IRQ=1, BLCK_WORKING=0 from next cycle, then IDLE; status outputs hold until next accept.
REQ-030 Command toggle in DONE cycle shall be discarded per REQ-020.

Reset
REQ-031 RST shall force IDLE; BLCK_WORKING, BLCK_IRQ, BLCK_ABRUPT_STOP, BLCK_FRDRAM_DEVERR, MEM_RE, MEM_WE, DEV_OUT_VALID, DEV_IN_READY = 0; BLCK_COUNT_SENT, MEM_ADDR, data regs, DEV_SEL = 0; issue copy = 0.
REQ-032 Reset mid-transfer shall abort silently: no IRQ pulse, no memory write in the reset cycle.
REQ-033 BLCK_ISSUE=1 at reset release shall be seen as one command on the first cycle.

Structure
REQ-034 Shared package holds state enumeration, direction encodings, and ADDR_W/DATA_W/CNT_W defaults.
REQ-035 Toggle detection shall be sub-module issue_toggle_det (registered copy, one-cycle change pulse).

Verification
REQ-036 Toggle 0->1, START=0x010, COUNT=4, SECTION=01, READY always 1 -> reads 0x010..0x013, 4 device words in order, IRQ one cycle after 4th, COUNT_SENT=4.
REQ-037 SECTION=00, COUNT=3, START=0xFFE, device words A,B,C -> writes 0xFFE=A, 0xFFF=B, 0x000=C, IRQ, COUNT_SENT=3.
REQ-038 COUNT=0 -> WORKING high one cycle, IRQ pulse, no MEM_RE/MEM_WE.
REQ-039 dev->mem COUNT=8, DEV_IN_ERR with 3rd word -> 2 writes, DEVERR=1, COUNT_SENT=2, IRQ.
REQ-040 mem->dev COUNT=8, ABORT after 5th handshake, second toggle mid-transfer -> ABRUPT_STOP=1, COUNT_SENT=5, second toggle ignored, IDLE after IRQ.
REQ-041 RST asserted mid dev->mem transfer -> all outputs per REQ-031 immediately, no IRQ.
